// File: rtl/uart_pkg.sv
// Shared UART definitions: baud timing constants, receiver state encoding
// and the odd-parity helper used by both tx and rx.
package uart_pkg;

  // 100 MHz system clock, 19200 baud.
  localparam int unsigned BIT_COUNT  = 5208;
  localparam int unsigned HALF_COUNT = 2604;
  localparam int unsigned TIMER_W    = 13;

  // Receiver FSM encoding; plain constants keep the encoding visible to
  // older tools and to anyone probing the state bus directly.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_BITS  = 3'd2;
  localparam state_t ST_PAR   = 3'd3;
  localparam state_t ST_STOP  = 3'd4;

  // Parity bit that makes the total count of ones in {data, parity} odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Synchronous active-high reset forces both stages to RESET_VAL.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back stages give the first flop a full cycle to settle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their inputs from the same edge; blocking here would collapse
    // the chain into a single flop.
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rx.sv
// UART receiver: 8 data bits LSB first, odd parity, 1 stop bit.
// Each bit is sampled at its centre (half-bit offset after the start edge,
// then whole-bit steps). Completed bytes are offered on Dout with a
// Receive/ReceiveAck level handshake; a new frame arriving before the ack
// overwrites Dout and sets the sticky Overrun flag.
// Build option: define RX_PARITY_CHECK_EN to report parity errors; without
// it the parity bit is still clocked through but ParityErr stays 0.
module rx #(
  parameter int unsigned BIT_COUNT  = uart_pkg::BIT_COUNT,
  parameter int unsigned HALF_COUNT = uart_pkg::HALF_COUNT
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Sin,
  input  logic       ReceiveAck,
  output logic       Receive,
  output logic [7:0] Dout,
  output logic       ParityErr,
  output logic       FramingErr,
  output logic       Overrun
);

  import uart_pkg::*;

  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(BIT_COUNT - 1);
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(HALF_COUNT - 1);

  logic               sin_s;
  state_t             state_q,   state_d;
  logic [TIMER_W-1:0] cnt_q,     cnt_d;
  logic [2:0]         bit_q,     bit_d;
  logic [7:0]         shift_q,   shift_d;
  logic               par_q,     par_d;
  logic               receive_q, receive_d;
  logic [7:0]         dout_q,    dout_d;
  logic               perr_q,    perr_d;
  logic               ferr_q,    ferr_d;
  logic               overrun_q, overrun_d;
  logic               timer_done;
  logic               half_done;
  logic               parity_err;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (Reset),
    .d     (Sin),
    .q     (sin_s)
  );

  assign timer_done = (cnt_q == BIT_LAST);
  assign half_done  = (cnt_q == HALF_LAST);

`ifdef RX_PARITY_CHECK_EN
  assign parity_err = (par_q != odd_parity(shift_q));
`else
  // Parity bit is consumed on the line but deliberately not judged.
  logic unused_par;
  assign unused_par = par_q;
  assign parity_err = 1'b0;
`endif

  // Next-state logic: frame FSM, baud timer, shifter and consumer handshake.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q + TIMER_W'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    receive_d = receive_q;
    dout_d    = dout_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    overrun_d = overrun_q;

    if (ReceiveAck) begin
      receive_d = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!sin_s) state_d = ST_START;
      end
      ST_START: begin
        if (half_done) begin
          cnt_d = '0;
          if (!sin_s) begin
            state_d = ST_BITS;
            bit_d   = 3'd0;
          end else begin
            // Low pulse shorter than half a bit: treat as noise.
            state_d = ST_IDLE;
          end
        end
      end
      ST_BITS: begin
        if (timer_done) begin
          cnt_d          = '0;
          shift_d[bit_q] = sin_s;
          if (bit_q == 3'd7) state_d = ST_PAR;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      ST_PAR: begin
        if (timer_done) begin
          cnt_d   = '0;
          par_d   = sin_s;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (timer_done) begin
          cnt_d     = '0;
          state_d   = ST_IDLE;
          // Completion overrides a same-cycle ack: the new byte is pending.
          receive_d = 1'b1;
          overrun_d = receive_q & ~ReceiveAck;
          dout_d    = shift_q;
          perr_d    = parity_err;
          ferr_d    = ~sin_s;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      receive_q <= 1'b0;
      dout_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      receive_q <= receive_d;
      dout_q    <= dout_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
    end
  end

  assign Receive    = receive_q;
  assign Dout       = dout_q;
  assign ParityErr  = perr_q;
  assign FramingErr = ferr_q;
  assign Overrun    = overrun_q;

endmodule
